// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding byte/half/word request, fixed latency,
// response held until the core accepts it.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W      = 4;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             accept_c;
  logic             err_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0]      word_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      load_c;
  logic [31:0]      hold_data;
  logic             hold_err;
  logic [31:0]      mem [DEPTH_WORDS];

  assign accept_c = req_valid && req_ready;
  assign idx_c    = addr[IDX_W+1:2];
  assign word_c   = mem[idx_c];

  // Request legality: strobes, funct3 per operation, alignment, range.
  always_comb begin
    err_c = 1'b0;
    if (MemRead == MemWrite) err_c = 1'b1;
    if (MemRead && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) err_c = 1'b1;
    if (MemWrite && !(funct3 inside {3'b000, 3'b001, 3'b010})) err_c = 1'b1;
    if ((funct3[1:0] == 2'b01) && addr[0]) err_c = 1'b1;
    if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) err_c = 1'b1;
    if (addr >= ADDR_LIMIT) err_c = 1'b1;
  end

  // Load extraction and sign/zero extension of the addressed lane.
  always_comb begin
    byte_c = 8'(word_c >> {addr[1:0], 3'b000});
    half_c = 16'(word_c >> {addr[1], 4'b0000});
    load_c = '0;
    if (MemRead && !err_c) begin
      case (funct3)
        3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
        3'b001:  load_c = {{16{half_c[15]}}, half_c};
        3'b010:  load_c = word_c;
        3'b100:  load_c = {24'd0, byte_c};
        3'b101:  load_c = {16'd0, half_c};
        default: load_c = '0;
      endcase
    end
  end

  // Next-state and latency counter.
  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (LATENCY <= 1) begin
            state_n = RESP;
            count_n = '0;
          end else begin
            state_n = WAIT;
            count_n = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        count_n = count - CNT_W'(1);
        if (count <= CNT_W'(1)) state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
          count_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  // Registered handshake outputs; response captured at acceptance, presented in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rdata     <= '0;
      rsp_err   <= 1'b0;
      hold_data <= '0;
      hold_err  <= 1'b0;
    end else begin
      req_ready <= (state_n == IDLE);
      rsp_valid <= (state_n == RESP);
      if (accept_c) begin
        hold_data <= load_c;
        hold_err  <= err_c;
      end
      if ((state_n == RESP) && (state != RESP)) begin
        rdata   <= (state == IDLE) ? load_c : hold_data;
        rsp_err <= (state == IDLE) ? err_c : hold_err;
      end else if (state_n != RESP) begin
        rdata   <= '0;
        rsp_err <= 1'b0;
      end
    end
  end

  // Store path; array contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_c && MemWrite && !err_c) begin
      case (funct3[1:0])
        2'b00:   mem[idx_c][{addr[1:0], 3'b000} +: 8] <= wdata[7:0];
        2'b01:   mem[idx_c][{addr[1], 4'b0000} +: 16] <= wdata[15:0];
        default: mem[idx_c] <= wdata;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan cases plus random traffic
// against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic        req_valid = 0, mem_read = 0, mem_write = 0, rsp_ready = 0;
  logic [31:0] addr_s = 0, wdata_s = 0;
  logic [2:0]  funct3_s = 0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rdata;

  logic        b_req_valid = 0, b_mem_read = 0, b_mem_write = 0, b_rsp_ready = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic [2:0]  b_funct3 = 0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_b [DEPTH*4];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(mem_read), .MemWrite(mem_write), .addr(addr_s), .funct3(funct3_s),
    .wdata(wdata_s), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rdata(rdata),
    .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .MemRead(b_mem_read), .MemWrite(b_mem_write), .addr(b_addr), .funct3(b_funct3),
    .wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rdata(b_rdata),
    .rsp_err(b_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: little-endian byte memory, legality from the access rules.
  task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    int size;
    logic [31:0] v;
    logic [8:0] bi;
    size = 1 << f3[1:0];
    e = (rd == wr);
    if (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) e = 1'b1;
    if (wr && (f3 > 3'd2)) e = 1'b1;
    if ((a & 32'(size - 1)) != 0) e = 1'b1;
    if (a >= 32'(DEPTH * 4)) e = 1'b1;
    d = '0;
    if (!e && wr)
      for (int i = 0; i < size; i++) begin
        bi = 9'(a + 32'(i));
        mem_b[bi] = 8'(wd >> (8 * i));
      end
    if (!e && rd) begin
      v = '0;
      for (int i = 0; i < size; i++) begin
        bi = 9'(a + 32'(i));
        v = v | (32'(mem_b[bi]) << (8 * i));
      end
      if (!f3[2] && (size < 4) && v[5'(8 * size - 1)]) v = v | (32'hFFFFFFFF << (8 * size));
      d = v;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One full transaction on the LATENCY=2 instance, optionally stalling the response.
  task automatic do_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] wd, input int hold,
                        output logic [31:0] got, output logic got_e);
    logic [31:0] exp_d;
    logic exp_e, busy, bad;
    int n;
    wait_ready();
    req_valid = 1; mem_read = rd; mem_write = wr; addr_s = a; funct3_s = f3; wdata_s = wd;
    rsp_ready = (hold == 0);
    model(rd, wr, a, f3, wd, exp_d, exp_e);
    @(posedge clk); #1;
    req_valid = 0; mem_read = 1'($urandom); mem_write = 1'($urandom);
    addr_s = $urandom; funct3_s = 3'($urandom); wdata_s = $urandom;
    n = 1; busy = 0;
    while (!rsp_valid && n < 20) begin
      if (req_ready) busy = 1;
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    got = rdata; got_e = rsp_err;
    chk({tag, "_rdata"}, rdata, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rdata !== exp_d || rsp_err !== exp_e || req_ready) bad = 1;
    end
    if (hold > 0) chk({tag, "_hold"}, 32'(bad), 32'd0);
    rsp_ready = 1;
    @(posedge clk); #1;
    chk({tag, "_done"}, {rsp_valid, rsp_err, req_ready, 29'd0} | rdata, {3'b001, 29'd0});
    rsp_ready = 1'($urandom);
  endtask

  // Transaction on the LATENCY=1 instance with explicit expectations.
  task automatic b_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
    int n = 0;
    while (!b_req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    b_req_valid = 1; b_mem_read = rd; b_mem_write = wr; b_addr = a; b_funct3 = f3; b_wdata = wd;
    b_rsp_ready = 1;
    @(posedge clk); #1;
    b_req_valid = 0; b_addr = $urandom;
    n = 1;
    while (!b_rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd1);
    chk({tag, "_rdata"}, b_rdata, exp_d);
    chk({tag, "_err"}, 32'(b_rsp_err), 32'(exp_e));
    @(posedge clk); #1;
    chk({tag, "_done"}, 32'({b_rsp_valid, b_req_ready}), 32'b01);
  endtask

  // Accept a request, then pulse reset while it is waiting.
  task automatic reset_mid(input string tag, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd);
    logic [31:0] exp_d;
    logic exp_e, seen;
    wait_ready();
    req_valid = 1; mem_read = !wr; mem_write = wr; addr_s = a; funct3_s = 3'b010; wdata_s = wd;
    rsp_ready = 1;
    model(!wr, wr, a, 3'b010, wd, exp_d, exp_e);
    @(posedge clk); #1;
    req_valid = 0;
    #2 reset_n = 0;
    #1;
    chk({tag, "_rst_out"}, 32'({rsp_valid, req_ready}), 32'b00);
    @(posedge clk); #2;
    reset_n = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    chk({tag, "_no_rsp"}, 32'(seen), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic ge, rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int sel, hold;
    for (int i = 0; i < DEPTH * 4; i++) mem_b[i] = 8'h00;

    // Reset values
    #12;
    chk("rst_outs", {rsp_valid, rsp_err, req_ready, 29'd0} | rdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd1);

    // LATENCY=1 instance
    b_req("l1_sw", 1, 0, 32'h40, 3'b010, 32'hCAFEF00D, 32'h0, 0);
    b_req("l1_sw_fix", 0, 1, 32'h40, 3'b010, 32'hCAFEF00D, 32'h0, 0);
    b_req("l1_lb", 1, 0, 32'h41, 3'b000, 32'h0, 32'hFFFFFFF0, 0);
    b_req("l1_lhu", 1, 0, 32'h42, 3'b101, 32'h0, 32'h0000CAFE, 0);
    b_req("l1_mis", 1, 0, 32'h41, 3'b010, 32'h0, 32'h0, 1);

    // Plan 1-3
    do_req("sw10", 0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 0, g, ge);
    chk("sw10_const", g, 32'h0);
    do_req("lw10", 1, 0, 32'h10, 3'b010, 32'h0, 0, g, ge);
    chk("lw10_const", g, 32'hDEADBEEF);
    do_req("lb13", 1, 0, 32'h13, 3'b000, 32'h0, 0, g, ge);
    chk("lb13_const", g, 32'hFFFFFFDE);
    do_req("lbu13", 1, 0, 32'h13, 3'b100, 32'h0, 0, g, ge);
    chk("lbu13_const", g, 32'h000000DE);
    do_req("lh10", 1, 0, 32'h10, 3'b001, 32'h0, 0, g, ge);
    chk("lh10_const", g, 32'hFFFFBEEF);
    do_req("lhu12", 1, 0, 32'h12, 3'b101, 32'h0, 0, g, ge);
    chk("lhu12_const", g, 32'h0000DEAD);
    do_req("sb11", 0, 1, 32'h11, 3'b000, 32'h000000AA, 0, g, ge);
    do_req("lw_sb", 1, 0, 32'h10, 3'b010, 32'h0, 0, g, ge);
    chk("lw_sb_const", g, 32'hDEADAAEF);
    do_req("sh12", 0, 1, 32'h12, 3'b001, 32'h00001234, 0, g, ge);
    do_req("lw_sh", 1, 0, 32'h10, 3'b010, 32'h0, 0, g, ge);
    chk("lw_sh_const", g, 32'h1234AAEF);

    // Plan 4: error cases leave the word untouched
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin rd = 1; wr = 0; a = 32'h12;  f3 = 3'b010; end
        1: begin rd = 0; wr = 1; a = 32'h11;  f3 = 3'b001; end
        2: begin rd = 1; wr = 1; a = 32'h10;  f3 = 3'b010; end
        3: begin rd = 1; wr = 0; a = 32'h10;  f3 = 3'b011; end
        4: begin rd = 0; wr = 1; a = 32'h200; f3 = 3'b010; end
        default: begin rd = 0; wr = 0; a = 32'h10; f3 = 3'b010; end
      endcase
      do_req("err", rd, wr, a, f3, 32'hFFFFFFFF, 0, g, ge);
      chk("err_flag", 32'(ge), 32'd1);
      do_req("err_after", 1, 0, 32'h10, 3'b010, 32'h0, 0, g, ge);
      chk("err_after_const", g, 32'h1234AAEF);
    end

    // Plan 5: stalled response
    do_req("stall", 1, 0, 32'h10, 3'b010, 32'h0, 5, g, ge);

    // Plan 6: reset during WAIT; a store accepted before reset stays committed
    reset_mid("rst_lw", 0, 32'h10, 32'h0);
    reset_mid("rst_sw", 1, 32'h14, 32'h55667788);
    do_req("rst_sw_chk", 1, 0, 32'h14, 3'b010, 32'h0, 0, g, ge);
    chk("rst_sw_const", g, 32'h55667788);

    // Fill the random window, then random traffic
    for (int w = 0; w < 8; w++) begin
      do_req("fill_lo", 0, 1, 32'(w * 4), 3'b010, $urandom, 0, g, ge);
      do_req("fill_hi", 0, 1, 32'h1F0 + 32'(w * 4) - 32'h10, 3'b010, $urandom, 0, g, ge);
    end
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 9);
      rd = (sel < 5);
      wr = (sel >= 5) && (sel < 9);
      if (sel == 9) {rd, wr} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end else f3 = 3'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 31));
        6, 7, 8: a = 32'h1E0 + 32'($urandom_range(0, 31));
        default: a = ($urandom_range(0, 1) != 0) ? 32'h200 + 32'($urandom_range(0, 1000)) : $urandom;
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_req("rnd", rd, wr, a, f3, $urandom, hold, g, ge);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the core's load/store path. Accepts one memory request at a time, carrying the MemRead/MemWrite strobes from the main control decoder, an ALU-computed byte address, store data and funct3. Performs byte, half or word access on an internal word array and returns load data, sign- or zero-extended per funct3, after a fixed latency. The response is held until the core accepts it; this allows the decoder to be reused in a stalling multicycle or pipelined datapath.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words in the array; valid byte addresses are 0 to DEPTH_WORDS*4-1.
LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range is 1 to 15.

Ports:
clk  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
MemRead  in  1  load request.
MemWrite  in  1  store request.
addr  in  32  byte address.
funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
wdata  in  32  store data; low byte/half is used for sb/sh.
rsp_valid  out  1  response present.
rsp_ready  in  1  core accepts response.
rdata  out  32  extended load data; 0 for stores and for errors.
rsp_err  out  1  request was rejected; no memory side effect occurred.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; req_ready=0 while reset_n=0, then 1; rsp_valid=0, rdata=0, rsp_err=0, latency counter=0. Array contents are not reset; they are zero-initialised at time 0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid && req_ready, the request is accepted, checked and executed, and the FSM goes to WAIT with count=LATENCY-1. If LATENCY=1, it goes straight to RESP.
  - WAIT: req_ready=0. Count decrements each cycle. At count==1 the next state is RESP.
  - RESP: rsp_valid=1; rdata and rsp_err stable. On rsp_ready the FSM returns to IDLE, rsp_valid drops the next cycle, and rdata/rsp_err clear to 0.
- Timing: request accepted at edge N gives rsp_valid=1 from cycle N+LATENCY. There is no back-to-back overlap; at most one request is outstanding.
- Execution on the acceptance edge:
  - Store: write byte enables derived from addr[1:0] and funct3.
  - Load: the word is read and extracted at the same edge and registered into a response register.
  - The array is a single-port read/write model.
- Error conditions. Each sets rsp_err=1, rdata=0, performs no write, and still completes the full latency and handshake:
  - MemRead && MemWrite both 1.
  - Neither MemRead nor MemWrite set.
  - funct3 not in the legal set for the operation (stores: only 000/001/010).
  - Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - addr >= DEPTH_WORDS*4.
- Extension rules:
  - lb: sign-extend bit 7 of the selected byte.
  - lh: sign-extend bit 15 of the selected half.
  - lbu/lhu: zero-extend.
  - lw: full word.
- Inputs other than req_valid are don't-care outside the acceptance cycle; they are not re-sampled while in WAIT or RESP.
- Reset asserted mid-operation: any pending response is discarded. A store accepted before reset remains committed.
- rsp_ready while not in RESP is ignored.

Test Plan:
1. Reset, then sw addr=0x10 wdata=0xDEADBEEF funct3=010, then lw addr=0x10 with rsp_ready=1 -> rsp_valid exactly 2 cycles after each acceptance; store rdata=0, err=0; load rdata=0xDEADBEEF.
2. After test 1: lb addr=0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
3. sb addr=0x11 wdata=0x000000AA, then lw 0x10 -> 0xDEADAAEF. sh addr=0x12 wdata=0x1234, then lw 0x10 -> 0x1234AAEF.
4. Error cases, each giving rsp_err=1, rdata=0 and the word unchanged on a following lw:
   - lw addr=0x12
   - sh addr=0x11
   - MemRead=MemWrite=1
   - funct3=011
   - addr=0x200 with DEPTH_WORDS=128
5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable and req_ready=0 throughout; raise rsp_ready -> IDLE next cycle, req_ready=1.
6. Accept a lw, then pulse reset_n low during WAIT -> rsp_valid immediately 0, no response delivered. With LATENCY=1: acceptance at edge N -> rsp_valid in cycle N+1.
